// File: rtl/demux_dispatch_ctrl.sv
// Steers one valid/ready stream into four one-entry lane holding registers, round-robin or by select.
// Latency 1 cycle; in_ready drops only when the target lane (or every lane, round-robin) is full and stalled.
module demux_dispatch_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               mode,
    input  logic [1:0]         sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [1:0]         ptr
);

    logic [3:0]            free;
    logic [1:0]            rr_target;
    logic [1:0]            target;
    logic                  xfer;
    logic [3:0][WIDTH-1:0] lane_q;

    // A full lane that drains this cycle can be reloaded in the same cycle.
    assign free = ~out_valid | out_ready;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        rr_target = ptr;
        found     = 1'b0;
        idx       = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && free[idx]) begin
                rr_target = idx;
                found     = 1'b1;
            end
        end
    end

    assign target   = mode ? sel : rr_target;
    assign in_ready = mode ? free[sel] : |free;
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 4'b0000;
            lane_q    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Load takes priority over drain so a word is never dropped.
                if (xfer && target == 2'(i)) begin
                    lane_q[i]    <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (xfer && !mode) begin
            ptr <= target + 2'd1;
        end
    end

    assign out_data = lane_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Vector table plus scoreboard bench for demux_dispatch_ctrl.
module tb_demux_dispatch_ctrl;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               mode;
    logic [1:0]         sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [1:0]         ptr;

    demux_dispatch_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             md;
        logic [1:0]       sl;
        logic [3:0]       ordy;
        logic             exp_rdy;
        logic [1:0]       exp_lane;
        logic [1:0]       exp_ptr;
        logic [3:0]       exp_ov;
    } vec_t;

    typedef struct packed {
        logic [1:0]       lane;
        logic [WIDTH-1:0] dat;
    } sb_t;

    vec_t tab[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string name, logic iv, logic [WIDTH-1:0] d, logic md,
                                logic [1:0] sl, logic [3:0] ordy, logic exp_rdy,
                                logic [1:0] exp_lane, logic [1:0] exp_ptr, logic [3:0] exp_ov);
        vec_t v;
        v.name = name; v.iv = iv; v.d = d; v.md = md; v.sl = sl; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_lane = exp_lane; v.exp_ptr = exp_ptr; v.exp_ov = exp_ov;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] lane_dat(int l);
        return out_data[l*WIDTH +: WIDTH];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, " ptr"}, 32'(ptr), 32'h0);
        chk({tag, " out_data"}, out_data, 32'h0);
    endtask

    // Called at posedge+1; leaves time at the following posedge+1.
    task automatic run_vec(input vec_t v);
        sb_t e;
        in_valid  = v.iv;
        in_data   = v.d;
        mode      = v.md;
        sel       = v.sl;
        out_ready = v.ordy;
        #1;
        chk({v.name, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        if (v.iv && v.exp_rdy) begin
            e.lane = v.exp_lane;
            e.dat  = v.d;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({v.name, " ptr"}, 32'(ptr), 32'(v.exp_ptr));
        chk({v.name, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({v.name, " lane data"}, 32'(lane_dat(int'(e.lane))), 32'(e.dat));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 4'b0000;
        #2;
        chk_cleared("reset");
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // name, iv, data, mode, sel, out_ready, exp in_ready, exp lane, exp ptr, exp out_valid
        tab.push_back(mk("rr0",     1, 8'h10, 0, 0, 4'b1111, 1, 0, 1, 4'b0001));
        tab.push_back(mk("rr1",     1, 8'h11, 0, 0, 4'b1111, 1, 1, 2, 4'b0010));
        tab.push_back(mk("rr2",     1, 8'h12, 0, 0, 4'b1111, 1, 2, 3, 4'b0100));
        tab.push_back(mk("rr3",     1, 8'h13, 0, 0, 4'b1111, 1, 3, 0, 4'b1000));
        tab.push_back(mk("rr4",     1, 8'h14, 0, 0, 4'b1111, 1, 0, 1, 4'b0001));
        tab.push_back(mk("hold1",   1, 8'h21, 0, 0, 4'b1101, 1, 1, 2, 4'b0010));
        tab.push_back(mk("fill2",   1, 8'h22, 0, 0, 4'b1101, 1, 2, 3, 4'b0110));
        tab.push_back(mk("fill3",   1, 8'h23, 0, 0, 4'b1101, 1, 3, 0, 4'b1010));
        tab.push_back(mk("fill0",   1, 8'h24, 0, 0, 4'b1101, 1, 0, 1, 4'b0011));
        tab.push_back(mk("skip",    1, 8'hA5, 0, 0, 4'b1101, 1, 2, 3, 4'b0110));
        tab.push_back(mk("dstall",  1, 8'h30, 1, 2, 4'b1001, 0, 0, 3, 4'b0110));
        tab.push_back(mk("drel",    1, 8'h30, 1, 2, 4'b1101, 1, 2, 3, 4'b0110));
        tab.push_back(mk("dfill0",  1, 8'h40, 1, 0, 4'b0000, 1, 0, 3, 4'b0111));
        tab.push_back(mk("rfill3",  1, 8'h43, 0, 0, 4'b0000, 1, 3, 0, 4'b1111));
        tab.push_back(mk("full_d",  1, 8'h50, 1, 1, 4'b0000, 0, 0, 0, 4'b1111));
        tab.push_back(mk("full_r",  1, 8'h51, 0, 0, 4'b0000, 0, 0, 0, 4'b1111));
        tab.push_back(mk("rel3",    1, 8'h60, 0, 0, 4'b1000, 1, 3, 0, 4'b1111));
        tab.push_back(mk("idle_rdy",0, 8'h66, 0, 0, 4'b0001, 1, 0, 0, 4'b1110));

        foreach (tab[i]) run_vec(tab[i]);

        chk("skip lane1 kept", 32'(lane_dat(1)), 32'h21);
        chk("lane2 kept",      32'(lane_dat(2)), 32'h30);
        chk("lane0 after drain", 32'(lane_dat(0)), 32'h40);
        chk("lane3 reload",    32'(lane_dat(3)), 32'h60);
        chk("sb empty",        32'(sbq.size()), 32'h0);

        // Asynchronous reset between edges with three lanes full.
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk_cleared("async rst");
        @(posedge clk);
        #1;
        chk_cleared("rst held");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        tab.delete();
        tab.push_back(mk("post0",   1, 8'h70, 0, 0, 4'b1111, 1, 0, 1, 4'b0001));
        tab.push_back(mk("post1",   1, 8'h71, 0, 0, 4'b1111, 1, 1, 2, 4'b0010));
        tab.push_back(mk("postdir", 1, 8'h72, 1, 3, 4'b1111, 1, 3, 2, 4'b1000));
        foreach (tab[i]) run_vec(tab[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
